// File: rtl/fib_pkg.sv
// Shared types and limits for the multi-lane Fibonacci stream generator.
package fib_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MAX_LANES = 4;

endpackage

// File: rtl/fib_step.sv
// Combinational expansion of {a,b} into LANES terms plus the next pair.
module fib_step #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 2
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   a_wrap,
    input  logic                   b_wrap,
    output logic [LANES*WIDTH-1:0] terms,
    output logic [LANES-1:0]       wraps,
    output logic [WIDTH-1:0]       next_a,
    output logic [WIDTH-1:0]       next_b,
    output logic                   next_a_wrap,
    output logic                   next_b_wrap
);

    logic [WIDTH-1:0] t [LANES+2];
    logic             w [LANES+2];
    logic [WIDTH:0]   sum;

    // a and b were produced by the previous beat, so their carry travels with them
    always_comb begin
        sum  = '0;
        t[0] = a;
        w[0] = a_wrap;
        t[1] = b;
        w[1] = b_wrap;
        for (int unsigned i = 2; i < LANES + 2; i++) begin
            sum  = {1'b0, t[i-1]} + {1'b0, t[i-2]};
            t[i] = sum[WIDTH-1:0];
            w[i] = sum[WIDTH];
        end
        terms = '0;
        wraps = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            terms[i*WIDTH +: WIDTH] = t[i];
            wraps[i]                = w[i];
        end
        next_a      = t[LANES];
        next_b      = t[LANES+1];
        next_a_wrap = w[LANES];
        next_b_wrap = w[LANES+1];
    end

endmodule

// File: rtl/fibonacci_stream.sv
// Programmable-length Fibonacci-type sequence source, LANES terms per valid/ready beat.
module fibonacci_stream
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LANES   = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       seed0,
    input  logic [WIDTH-1:0]       seed1,
    input  logic [COUNT_W-1:0]     count,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_num,
    output logic [LANES-1:0]       out_lane_valid,
    output logic                   out_last,
    output logic                   out_ovf,
    output logic                   done
);

    if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
        $error("fibonacci_stream: LANES out of range");
    end

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               a_wrap;
    logic               b_wrap;
    logic [COUNT_W-1:0] remaining;
    logic               ovf_sticky;

    logic [LANES*WIDTH-1:0] terms;
    logic [LANES-1:0]       wraps;
    logic [WIDTH-1:0]       next_a;
    logic [WIDTH-1:0]       next_b;
    logic                   next_a_wrap;
    logic                   next_b_wrap;
    logic [LANES-1:0]       lane_mask;
    logic                   last_beat;
    logic                   run;

    fib_step #(
        .WIDTH(WIDTH),
        .LANES(LANES)
    ) u_step (
        .a           (a),
        .b           (b),
        .a_wrap      (a_wrap),
        .b_wrap      (b_wrap),
        .terms       (terms),
        .wraps       (wraps),
        .next_a      (next_a),
        .next_b      (next_b),
        .next_a_wrap (next_a_wrap),
        .next_b_wrap (next_b_wrap)
    );

    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_mask[i] = remaining > COUNT_W'(i);
        end
        run       = (state == RUN);
        last_beat = remaining <= COUNT_W'(LANES);

        busy           = run;
        out_valid      = run;
        out_num        = run ? terms : '0;
        out_lane_valid = run ? lane_mask : '0;
        out_last       = run & last_beat;
        // in IDLE the sticky flag alone carries the completed run's verdict
        out_ovf        = ovf_sticky | (run & (|(wraps & lane_mask)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            a_wrap     <= 1'b0;
            b_wrap     <= 1'b0;
            remaining  <= '0;
            ovf_sticky <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a          <= seed0;
                        b          <= seed1;
                        a_wrap     <= 1'b0;
                        b_wrap     <= 1'b0;
                        remaining  <= count;
                        ovf_sticky <= 1'b0;
                        if (count != '0) begin
                            state <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        a          <= next_a;
                        b          <= next_b;
                        a_wrap     <= next_a_wrap;
                        b_wrap     <= next_b_wrap;
                        remaining  <= last_beat ? '0 : remaining - COUNT_W'(LANES);
                        ovf_sticky <= out_ovf;
                        if (last_beat) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_stream.sv
// Directed bench for fibonacci_stream: LANES=2 main instance plus LANES=1/3 instances.
module tb_fibonacci_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed0;
    logic [15:0] seed1;
    logic [15:0] count;
    logic        out_ready;

    logic        busy2, out_valid2, out_last2, out_ovf2, done2;
    logic [31:0] out_num2;
    logic [1:0]  lv2;

    logic        busy1, out_valid1, out_last1, out_ovf1, done1;
    logic [15:0] out_num1;
    logic [0:0]  lv1;

    logic        busy3, out_valid3, out_last3, out_ovf3, done3;
    logic [47:0] out_num3;
    logic [2:0]  lv3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fibonacci_stream #(.WIDTH(16), .LANES(2), .COUNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1), .count(count),
        .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready), .out_num(out_num2),
        .out_lane_valid(lv2), .out_last(out_last2), .out_ovf(out_ovf2), .done(done2)
    );

    fibonacci_stream #(.WIDTH(16), .LANES(1), .COUNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1), .count(count),
        .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready), .out_num(out_num1),
        .out_lane_valid(lv1), .out_last(out_last1), .out_ovf(out_ovf1), .done(done1)
    );

    fibonacci_stream #(.WIDTH(16), .LANES(3), .COUNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1), .count(count),
        .busy(busy3), .out_valid(out_valid3), .out_ready(out_ready), .out_num(out_num3),
        .out_lane_valid(lv3), .out_last(out_last3), .out_ovf(out_ovf3), .done(done3)
    );

    typedef struct {
        logic [15:0] l0;
        logic [15:0] l1;
        logic [1:0]  lv;
        logic        last;
        logic        ovf;
    } beat_t;

    typedef struct {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] cnt;
        int          first;
        int          n;
    } run_t;

    beat_t exp_tbl [8];
    run_t  runs [2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input beat_t e);
        chk({tag, "_valid"}, {31'd0, out_valid2}, 32'd1);
        chk({tag, "_lv"}, {30'd0, lv2}, {30'd0, e.lv});
        chk({tag, "_lane0"}, {16'd0, out_num2[15:0]}, {16'd0, e.l0});
        if (e.lv[1]) chk({tag, "_lane1"}, {16'd0, out_num2[31:16]}, {16'd0, e.l1});
        chk({tag, "_last"}, {31'd0, out_last2}, {31'd0, e.last});
        chk({tag, "_ovf"}, {31'd0, out_ovf2}, {31'd0, e.ovf});
        chk({tag, "_done"}, {31'd0, done2}, 32'd0);
    endtask

    task automatic launch(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] c);
        seed0 = s0;
        seed1 = s1;
        count = c;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done2 && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, done2}, 32'd1);
    endtask

    task automatic finish_checks(input string tag);
        chk({tag, "_done_pulse"}, {31'd0, done2}, 32'd1);
        chk({tag, "_busy_low"}, {31'd0, busy2}, 32'd0);
        tick;
        chk({tag, "_done_clear"}, {31'd0, done2}, 32'd0);
    endtask

    logic [15:0] f [26];
    logic        w [26];
    logic [16:0] s;
    logic        sticky;
    int          ref_seq [7];
    int          q1 [$];
    int          q3 [$];
    logic        d1_seen, d3_seen;

    initial begin
        exp_tbl[0] = '{16'd1,  16'd1,  2'b11, 1'b0, 1'b0};
        exp_tbl[1] = '{16'd2,  16'd3,  2'b11, 1'b0, 1'b0};
        exp_tbl[2] = '{16'd5,  16'd8,  2'b11, 1'b0, 1'b0};
        exp_tbl[3] = '{16'd13, 16'd21, 2'b11, 1'b0, 1'b0};
        exp_tbl[4] = '{16'd34, 16'd55, 2'b11, 1'b1, 1'b0};
        exp_tbl[5] = '{16'd2,  16'd1,  2'b11, 1'b0, 1'b0};
        exp_tbl[6] = '{16'd3,  16'd4,  2'b11, 1'b0, 1'b0};
        exp_tbl[7] = '{16'd7,  16'd0,  2'b01, 1'b1, 1'b0};
        runs[0] = '{16'd1, 16'd1, 16'd10, 0, 5};
        runs[1] = '{16'd2, 16'd1, 16'd5,  5, 3};
        ref_seq = '{1, 1, 2, 3, 5, 8, 13};

        rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; count = '0; out_ready = 1'b1;
        tick;
        tick;
        chk("rst_busy", {31'd0, busy2}, 32'd0);
        chk("rst_valid", {31'd0, out_valid2}, 32'd0);
        chk("rst_num", out_num2, 32'd0);
        chk("rst_lv", {30'd0, lv2}, 32'd0);
        chk("rst_last_ovf_done", {29'd0, out_last2, out_ovf2, done2}, 32'd0);
        rst = 1'b0;
        tick;

        for (int r = 0; r < 2; r++) begin
            launch(runs[r].s0, runs[r].s1, runs[r].cnt);
            chk($sformatf("run%0d_busy", r), {31'd0, busy2}, 32'd1);
            for (int k = 0; k < runs[r].n; k++) begin
                chk_beat($sformatf("run%0d_b%0d", r, k), exp_tbl[runs[r].first + k]);
                tick;
            end
            finish_checks($sformatf("run%0d", r));
        end

        // backpressure on the second beat
        launch(16'd1, 16'd1, 16'd10);
        chk_beat("bp_b0", exp_tbl[0]);
        tick;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk_beat($sformatf("bp_hold%0d", c), exp_tbl[1]);
        end
        out_ready = 1'b1;
        chk_beat("bp_b1", exp_tbl[1]);
        tick;
        chk_beat("bp_b2", exp_tbl[2]);
        tick;
        wait_done("bp");
        tick;

        // overflow run: reference terms modulo 2^16 with carry flags
        f[0] = 16'd1; f[1] = 16'd1; w[0] = 1'b0; w[1] = 1'b0;
        for (int n = 2; n < 26; n++) begin
            s = {1'b0, f[n-1]} + {1'b0, f[n-2]};
            f[n] = s[15:0];
            w[n] = s[16];
        end
        sticky = 1'b0;
        launch(16'd1, 16'd1, 16'd26);
        for (int k = 0; k < 13; k++) begin
            beat_t e;
            e.l0 = f[2*k]; e.l1 = f[2*k+1]; e.lv = 2'b11; e.last = (k == 12);
            e.ovf = sticky | w[2*k] | w[2*k+1];
            chk_beat($sformatf("ovf_b%0d", k), e);
            if (k == 11) chk("ovf_b11_clear", {31'd0, out_ovf2}, 32'd0);
            if (k == 12) begin
                chk("ovf_b12_f24", {16'd0, out_num2[15:0]}, 32'd9489);
                chk("ovf_b12_flag", {31'd0, out_ovf2}, 32'd1);
            end
            sticky = e.ovf;
            tick;
        end
        finish_checks("ovf");
        chk("ovf_idle_keep", {31'd0, out_ovf2}, 32'd1);
        tick;
        chk("ovf_idle_keep2", {31'd0, out_ovf2}, 32'd1);

        // zero-length run
        launch(16'd5, 16'd5, 16'd0);
        chk("zero_busy", {31'd0, busy2}, 32'd0);
        chk("zero_valid", {31'd0, out_valid2}, 32'd0);
        chk("zero_done", {31'd0, done2}, 32'd1);
        chk("zero_ovf_cleared", {31'd0, out_ovf2}, 32'd0);
        tick;
        chk("zero_done_clear", {31'd0, done2}, 32'd0);
        chk("zero_valid2", {31'd0, out_valid2}, 32'd0);

        // start held high with different seeds during the run
        launch(16'd1, 16'd1, 16'd10);
        seed0 = 16'd9; seed1 = 16'd9; count = 16'd2; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_beat($sformatf("sbusy_b%0d", k), exp_tbl[k]);
            tick;
        end
        start = 1'b0;
        finish_checks("sbusy");

        // asynchronous reset mid-run
        launch(16'd1, 16'd1, 16'd10);
        tick;
        chk_beat("arst_b1", exp_tbl[1]);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy2}, 32'd0);
        chk("arst_valid", {31'd0, out_valid2}, 32'd0);
        chk("arst_num", out_num2, 32'd0);
        chk("arst_lv_last_ovf_done", {27'd0, lv2, out_last2, out_ovf2, done2}, 32'd0);
        tick;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("arst_nodone%0d", c), {30'd0, done2, busy2}, 32'd0);
            tick;
        end

        // LANES=1 and LANES=3 must produce the same flat term stream
        d1_seen = 1'b0;
        d3_seen = 1'b0;
        launch(16'd1, 16'd1, 16'd7);
        for (int c = 0; c < 30; c++) begin
            if (out_valid1) q1.push_back(int'(out_num1));
            if (out_valid3) begin
                for (int i = 0; i < 3; i++) begin
                    if (lv3[i]) q3.push_back(int'(out_num3[i*16 +: 16]));
                end
            end
            d1_seen = d1_seen | done1;
            d3_seen = d3_seen | done3;
            tick;
        end
        chk("l1_len", q1.size(), 32'd7);
        chk("l3_len", q3.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("l1_term%0d", i), (i < q1.size()) ? q1[i] : 32'hdead, ref_seq[i]);
            chk($sformatf("l3_term%0d", i), (i < q3.size()) ? q3[i] : 32'hdead, ref_seq[i]);
        end
        chk("l1_l3_done", {30'd0, d1_seen, d3_seen}, 32'd3);
        chk("l1_l3_idle", {26'd0, busy1, out_last1, out_ovf1, busy3, out_last3, out_ovf3}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fibonacci_stream.md
Name: fibonacci_stream

Overview:
- Parametrised multi-lane successor of the team's Fibonacci generators.
- Emits a programmable-length run of a Fibonacci-type recurrence, LANES terms per beat, over a valid/ready stream.
- Seeds are programmable; term count is programmable; a sticky overflow flag reports wrap-around.
- Used as a test-pattern and sequence source feeding downstream stream consumers.

Parameters:
- WIDTH, 16, bit width of each term; arithmetic is modulo 2^WIDTH.
- LANES, 2, terms per beat; legal range 1..4.
- COUNT_W, 16, width of the term-count input.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  start request; sampled only in IDLE
- seed0  input  WIDTH  term F(0)
- seed1  input  WIDTH  term F(1)
- count  input  COUNT_W  number of terms to emit
- busy  output  1  high while in RUN
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accepts beat
- out_num  output  LANES*WIDTH  lane i holds bits [i*WIDTH +: WIDTH]
- out_lane_valid  output  LANES  per-lane valid mask; only the last beat can be partial
- out_last  output  1  final beat of the run
- out_ovf  output  1  some emitted term of this run so far (up to and including the current beat) wrapped
- done  output  1  one-cycle pulse when a run completes

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- On reset:
  - State is IDLE.
  - All outputs are 0: busy, out_valid, out_num, out_lane_valid, out_last, out_ovf and done.
  - Internal a, b, remaining and ovf_sticky are all 0.
- Recurrence: F(0)=seed0, F(1)=seed1, F(n)=F(n-1)+F(n-2) mod 2^WIDTH.
- Beat content: beat k, lane i, carries F(k*LANES+i).
- Start acceptance: IDLE with start=1 at a clock edge:
  - latches a=seed0, b=seed1, remaining=count;
  - clears ovf_sticky;
  - goes to RUN if count!=0.
- Zero-length run: if count==0, stay in IDLE and pulse done in the next cycle. No beat is emitted.
- Start while busy: start in RUN is ignored, and seeds and count are not resampled.
- RUN outputs:
  - out_valid=1.
  - out_num is the LANES terms expanded combinationally from {a,b}.
  - out_lane_valid has its low min(remaining,LANES) bits set.
  - out_last=(remaining<=LANES).
- Backpressure: with out_valid=1 and out_ready=0, every output holds stable.
- Handshake (out_valid & out_ready):
  - {a,b} advances LANES terms.
  - remaining -= LANES, saturating at 0.
  - ovf_sticky |= out_ovf.
- Run completion: a handshake with out_last=1 moves to IDLE and pulses done in the following cycle. busy drops in the same cycle done rises.
- Overflow detection:
  - Each term with n>=2 is computed at WIDTH+1 bits; the carry-out is that lane's wrap bit.
  - Seed terms never set a wrap bit.
  - out_ovf = ovf_sticky | OR over lanes of (wrap & out_lane_valid).
  - Lanes masked off by out_lane_valid are ignored.
- out_ovf in IDLE: keeps the final value of the completed run until the next start is accepted.
- Reset mid-run: returns immediately to reset values. No done pulse; a partial run is lost.
- Partial last beat: lanes with out_lane_valid=0 may carry any value; the bench must not check them.

Decomposition:
- Shared package fib_pkg holds:
  - typedef enum state_t {IDLE, RUN};
  - localparam MAX_LANES=4.
- Sub-module fib_step (combinational): inputs a, b; outputs:
  - the LANES terms;
  - the LANES wrap bits;
  - next a, next b (the terms at LANES and LANES+1).
- fibonacci_stream instantiates one fib_step and holds the state machine, remaining counter and sticky flag.

Test Plan:
- Basic run: LANES=2, seeds 1,1, count=10, out_ready=1.
  - Expected: beats (1,1) (2,3) (5,8) (13,21) (34,55).
  - out_last on beat 5 only; done pulses once; out_ovf=0 throughout.
- Partial beat: LANES=2, seeds 2,1, count=5.
  - Expected: beats (2,1) (3,4) (7,x); out_lane_valid 11,11,01; out_last on beat 3.
- Backpressure: count=10, out_ready low for 3 cycles on beat 2.
  - Expected: out_num holds 2,3 unchanged and out_valid stays 1.
  - After ready returns, the sequence continues with (5,8) and no term is skipped.
- Overflow: WIDTH=16, LANES=2, seeds 1,1, count=26.
  - Expected: beat 12 carries lane0 F(24)=9489 (75025 wrapped) with out_ovf=1.
  - Beats 0..11 have out_ovf=0; beat 12 has out_ovf=1; out_ovf stays 1 after done.
- Edge cases: count=0, start pulsed during RUN, rst asserted mid-run.
  - count=0: no out_valid, done pulses in the next cycle.
  - start during RUN: the run is unaffected.
  - rst mid-run: all outputs go to 0 asynchronously and no done pulse occurs.
- LANES=1 and LANES=3 with seeds 1,1 and count=7: the term stream equals the LANES=1 reference sequence 1,1,2,3,5,8,13.
